// File: rtl/frame_arbiter_if.sv
// Bundle of source, filter-engine and result signals for frame_arbiter.
// The slave view belongs to the arbiter; the master view belongs to the environment.
interface frame_arbiter_if;
  logic        req0;
  logic        req1;
  logic        vld0;
  logic        vld1;
  logic [7:0]  din0;
  logic [7:0]  din1;
  logic        gnt0;
  logic        gnt1;
  logic        f_valid;
  logic [7:0]  f_din;
  logic        f_rst;
  logic        f_fill_now;
  logic [15:0] f_dout;
  logic [15:0] res_out;
  logic        res_valid;
  logic        res_src;
  logic        frame_done;
  logic        err;

  modport slave (
    input  req0, req1, vld0, vld1, din0, din1, f_fill_now, f_dout,
    output gnt0, gnt1, f_valid, f_din, f_rst, res_out, res_valid, res_src,
           frame_done, err
  );

  modport master (
    output req0, req1, vld0, vld1, din0, din1, f_fill_now, f_dout,
    input  gnt0, gnt1, f_valid, f_din, f_rst, res_out, res_valid, res_src,
           frame_done, err
  );
endinterface

// File: rtl/frame_arbiter.sv
// Two-source round-robin frame arbiter: buffers one N*M frame, bursts it to a
// shared filter engine, collects the interior results and guards with a watchdog.
module frame_arbiter #(
  parameter int N      = 5,
  parameter int M      = 5,
  parameter int WD_LIM = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  frame_arbiter_if.slave bus
);
  localparam int NPIX = N * M;
  localparam int NRES = (N - 2) * (M - 2);
  localparam int CW   = $clog2(NPIX + 1);
  localparam int AW   = $clog2(NPIX);
  localparam int RW   = $clog2(NRES + 1);
  localparam int WW   = $clog2(WD_LIM + 1);

  localparam logic [CW-1:0] PIX_LAST = CW'(NPIX - 1);
  localparam logic [CW-1:0] PIX_END  = CW'(NPIX);
  localparam logic [RW-1:0] RES_ALL  = RW'(NRES);
  localparam logic [WW-1:0] WD_LAST  = WW'(WD_LIM - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, BURST, WAIT, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] pix_cnt_reg, pix_cnt_next;
  logic [RW-1:0] res_cnt_reg, res_cnt_next;
  logic [WW-1:0] wd_cnt_reg, wd_cnt_next;
  logic          lc_odd_reg, lc_odd_next;
  logic          prio_reg, prio_next;
  logic          src_reg, src_next;
  logic          gnt_reg, gnt_next;
  logic          err_reg, err_next;
  logic          res_valid_reg, res_valid_next;
  logic [15:0]   res_out_reg, res_out_next;

  logic [7:0]    buffer [NPIX];
  logic [7:0]    rd_data_reg;
  logic [7:0]    wr_data;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic          capture;
  logic          done_go;
  logic          timeout;

  assign wr_addr = pix_cnt_reg[AW-1:0];
  assign rd_addr = (pix_cnt_reg < PIX_END) ? pix_cnt_reg[AW-1:0] : '0;
  assign wr_data = src_reg ? bus.din1 : bus.din0;

  // Read runs one address ahead so burst cycle k presents buffer[k-1].
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer[wr_addr] <= wr_data;
    end
    rd_data_reg <= buffer[rd_addr];
  end

  always_comb begin
    state_next     = state_reg;
    pix_cnt_next   = pix_cnt_reg;
    res_cnt_next   = res_cnt_reg;
    wd_cnt_next    = wd_cnt_reg;
    lc_odd_next    = lc_odd_reg;
    prio_next      = prio_reg;
    src_next       = src_reg;
    gnt_next       = gnt_reg;
    err_next       = 1'b0;
    res_valid_next = 1'b0;
    res_out_next   = res_out_reg;
    wr_en          = 1'b0;
    capture        = 1'b0;
    done_go        = 1'b0;
    timeout        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // prio_reg remembers the last served source; the other one wins a tie.
          src_next     = (bus.req0 && bus.req1) ? ~prio_reg : bus.req1;
          gnt_next     = 1'b1;
          pix_cnt_next = '0;
          state_next   = COLLECT;
        end
      end
      COLLECT: begin
        wr_en = src_reg ? bus.vld1 : bus.vld0;
        if (wr_en) begin
          if (pix_cnt_reg == PIX_LAST) begin
            pix_cnt_next = '0;
            state_next   = BURST;
          end else begin
            pix_cnt_next = pix_cnt_reg + 1'b1;
          end
        end
      end
      BURST: begin
        if (pix_cnt_reg == PIX_END) begin
          wd_cnt_next  = '0;
          res_cnt_next = '0;
          state_next   = WAIT;
        end else begin
          pix_cnt_next = pix_cnt_reg + 1'b1;
        end
      end
      WAIT: begin
        wd_cnt_next = wd_cnt_reg + 1'b1;
        if (!bus.f_fill_now) begin
          lc_odd_next = 1'b1;
          state_next  = DRAIN;
        end
      end
      DRAIN: begin
        wd_cnt_next = wd_cnt_reg + 1'b1;
        if (!bus.f_fill_now) begin
          lc_odd_next = ~lc_odd_reg;
          // Odd count now means the current low cycle is even.
          capture     = lc_odd_reg && (res_cnt_reg != RES_ALL);
        end else if (res_cnt_reg == RES_ALL) begin
          done_go    = 1'b1;
          gnt_next   = 1'b0;
          prio_next  = src_reg;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    timeout = ((state_reg == WAIT) || (state_reg == DRAIN)) && (wd_cnt_reg == WD_LAST);
    if (timeout && !done_go) begin
      state_next = IDLE;
      gnt_next   = 1'b0;
      prio_next  = src_reg;
      err_next   = 1'b1;
      capture    = 1'b0;
    end

    if (capture) begin
      res_out_next   = bus.f_dout;
      res_valid_next = 1'b1;
      res_cnt_next   = res_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pix_cnt_reg   <= '0;
      res_cnt_reg   <= '0;
      wd_cnt_reg    <= '0;
      lc_odd_reg    <= 1'b0;
      prio_reg      <= 1'b1;
      src_reg       <= 1'b0;
      gnt_reg       <= 1'b0;
      err_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      res_out_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      pix_cnt_reg   <= pix_cnt_next;
      res_cnt_reg   <= res_cnt_next;
      wd_cnt_reg    <= wd_cnt_next;
      lc_odd_reg    <= lc_odd_next;
      prio_reg      <= prio_next;
      src_reg       <= src_next;
      gnt_reg       <= gnt_next;
      err_reg       <= err_next;
      res_valid_reg <= res_valid_next;
      res_out_reg   <= res_out_next;
    end
  end

  assign bus.gnt0       = gnt_reg & ~src_reg;
  assign bus.gnt1       = gnt_reg & src_reg;
  assign bus.f_valid    = (state_reg == BURST) && (pix_cnt_reg == '0);
  assign bus.f_din      = ((state_reg == BURST) && (pix_cnt_reg != '0)) ? rd_data_reg : 8'h00;
  assign bus.f_rst      = ~rst_n | err_reg;
  assign bus.res_out    = res_out_reg;
  assign bus.res_valid  = res_valid_reg;
  assign bus.res_src    = src_reg;
  assign bus.frame_done = (state_reg == DONE);
  assign bus.err        = err_reg;
endmodule

// File: tb/tb_frame_arbiter.sv
// Bench for frame_arbiter: scripted frame table, reset/back-to-back sequences and
// random frames, all scored against a frame-level model and a behavioural filter.
module tb_frame_arbiter;
  localparam int N      = 5;
  localparam int M      = 5;
  localparam int WD_LIM = 32;
  localparam int NPIX   = N * M;
  localparam int NRES   = (N - 2) * (M - 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_arbiter_if bus();
  frame_arbiter #(.N(N), .M(M), .WD_LIM(WD_LIM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct {
    bit r0; bit r1; bit gap; bit stuck; int exp_src; bit exp_err;
  } fvec_t;

  int errors = 0;
  int checks = 0;

  // filter model state
  logic [7:0]  fbuf [NPIX];
  logic [15:0] fres [NRES];
  int lidx = 0;
  bit loading = 0;
  int low_start = -1;
  bit stuck_mode = 0;
  int fdelay = 0;

  // monitor and scoreboard state
  int cyc = 0, fvalid_cnt = 0, burst_k = 0, burst_n = 0, burst_end_cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, inv_viol = 0;
  int res_total = 0, grant_cyc = 0, last_served = 1;
  bit gnt_at_end = 0, frst_at_err = 0;
  logic [15:0] obs_res[$];
  logic [7:0]  obs_burst [NPIX];
  logic [7:0]  exp_pix [NPIX];
  logic [15:0] exp_res [NRES];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // 3x3 window sum plus the centre again, for interior pixel k in row-major order.
  function automatic logic [15:0] conv(input logic [7:0] px [NPIX], input int k);
    int r, c;
    logic [15:0] s;
    r = k / (M - 2) + 1;
    c = k % (M - 2) + 1;
    s = 16'(px[r * M + c]);
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        s = s + 16'(px[(r + dr) * M + c + dc]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (low_start >= 0 && cyc >= low_start && (cyc - low_start) < 2 * NRES) begin
      bus.f_fill_now = 1'b0;
      bus.f_dout     = fres[(cyc - low_start) / 2];
    end else begin
      bus.f_fill_now = 1'b1;
      bus.f_dout     = 16'hbeef;
    end
    if (bus.f_rst) begin
      loading = 0;
      low_start = -1;
    end else if (bus.f_valid) begin
      loading = 1;
      lidx = 0;
      low_start = -1;
    end else if (loading) begin
      fbuf[lidx] = bus.f_din;
      lidx++;
      if (lidx == NPIX) begin
        loading = 0;
        for (int k = 0; k < NRES; k++) fres[k] = conv(fbuf, k);
        low_start = stuck_mode ? -1 : cyc + 1 + fdelay;
      end
    end
    if (burst_k > 0) begin
      obs_burst[burst_k - 1] = bus.f_din;
      burst_n++;
      if (burst_k == NPIX) begin
        burst_k = 0;
        burst_end_cyc = cyc;
      end else begin
        burst_k++;
      end
    end else if (bus.f_din != 8'h00) begin
      inv_viol++;
    end
    if (bus.f_valid) begin
      fvalid_cnt++;
      burst_k = 1;
    end
    if (bus.gnt0 && bus.gnt1) inv_viol++;
    if (bus.res_valid && bus.err) inv_viol++;
    if (bus.res_valid) begin
      obs_res.push_back(bus.res_out);
      res_total++;
    end
    if (bus.frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      gnt_at_end = bus.gnt0 | bus.gnt1;
    end
    if (bus.err) begin
      err_cnt++;
      err_cyc = cyc;
      gnt_at_end = bus.gnt0 | bus.gnt1;
      frst_at_err = bus.f_rst;
    end
    if (!rst_n) burst_k = 0;
  endtask

  task automatic new_pixels();
    for (int i = 0; i < NPIX; i++) exp_pix[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < NRES; k++) exp_res[k] = conv(exp_pix, k);
  endtask

  task automatic feed(input int src, input bit gap);
    int p;
    bit on, vg;
    p = 0;
    on = 1;
    while (p < NPIX) begin
      vg = gap ? on : 1'b1;
      if (src == 0) begin
        bus.vld0 = vg;
        bus.din0 = vg ? exp_pix[p] : 8'($urandom);
        bus.vld1 = 1'($urandom);
        bus.din1 = 8'($urandom);
      end else begin
        bus.vld1 = vg;
        bus.din1 = vg ? exp_pix[p] : 8'($urandom);
        bus.vld0 = 1'($urandom);
        bus.din0 = 8'($urandom);
      end
      tick();
      if (vg) p++;
      on = ~on;
    end
    bus.vld0 = 1'b0;
    bus.vld1 = 1'b0;
  endtask

  task automatic run_frame(input bit r0, input bit r1, input bit gap, input bit stuck,
                           input bit keep, input int exp_src, input bit exp_err,
                           input string tag);
    int n, mism;
    stuck_mode = stuck;
    fdelay = $urandom_range(0, 3);
    new_pixels();
    bus.req0 = r0;
    bus.req1 = r1;
    n = 0;
    while (!(bus.gnt0 || bus.gnt1) && n < 20) begin
      tick();
      n++;
    end
    grant_cyc = cyc;
    check({tag, "_granted"}, 32'(bus.gnt0 | bus.gnt1), 32'd1);
    if (!(bus.gnt0 || bus.gnt1)) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      return;
    end
    check({tag, "_gnt_src"}, 32'(bus.gnt1), 32'(exp_src));
    check({tag, "_res_src"}, 32'(bus.res_src), 32'(exp_src));
    if (!keep) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    fvalid_cnt = 0;
    burst_n = 0;
    done_cnt = 0;
    err_cnt = 0;
    obs_res.delete();
    feed(exp_src, gap);
    n = 0;
    while (done_cnt == 0 && err_cnt == 0 && n < 400) begin
      tick();
      n++;
    end
    if (!keep) repeat (3) tick();
    check({tag, "_fvalid_cnt"}, 32'(fvalid_cnt), 32'd1);
    check({tag, "_burst_len"}, 32'(burst_n), 32'(NPIX));
    mism = 0;
    for (int i = 0; i < NPIX; i++) if (obs_burst[i] !== exp_pix[i]) mism++;
    check({tag, "_burst_bytes_bad"}, 32'(mism), 32'd0);
    check({tag, "_gnt_at_end"}, 32'(gnt_at_end), 32'd0);
    if (exp_err) begin
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'd1);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd0);
      check({tag, "_err_cycle"}, 32'(err_cyc), 32'(burst_end_cyc + 1 + WD_LIM));
      check({tag, "_f_rst_at_err"}, 32'(frst_at_err), 32'd1);
      check({tag, "_res_cnt"}, 32'(obs_res.size()), 32'd0);
    end else begin
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
      check({tag, "_res_cnt"}, 32'(obs_res.size()), 32'(NRES));
      mism = 0;
      for (int k = 0; k < NRES && k < obs_res.size(); k++)
        if (obs_res[k] !== exp_res[k]) mism++;
      check({tag, "_res_values_bad"}, 32'(mism), 32'd0);
      check({tag, "_res_out_hold"}, 32'(bus.res_out), 32'(exp_res[NRES - 1]));
    end
    last_served = exp_src;
    $display("frame %s src=%0d bursts=%0d results=%0d done=%0d err=%0d",
             tag, exp_src, fvalid_cnt, obs_res.size(), done_cnt, err_cnt);
  endtask

  fvec_t tbl [10];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n, res_base, d, exp;
    bit r0, r1, g, s;

    bus.req0 = 0; bus.req1 = 0; bus.vld0 = 0; bus.vld1 = 0;
    bus.din0 = 0; bus.din1 = 0; bus.f_fill_now = 1; bus.f_dout = 0;

    // r0 r1 gap stuck exp_src exp_err ; starts with source 0 favoured
    tbl[0] = '{1, 1, 0, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 1, 0};
    tbl[2] = '{1, 1, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 1, 0};
    tbl[5] = '{1, 0, 1, 0, 0, 0};
    tbl[6] = '{1, 1, 0, 0, 1, 0};
    tbl[7] = '{1, 0, 0, 1, 0, 1};
    tbl[8] = '{1, 1, 0, 0, 1, 0};
    tbl[9] = '{1, 1, 0, 0, 0, 0};

    repeat (3) tick();
    check("rst_ctrl_vec", 32'({bus.gnt0, bus.gnt1, bus.f_valid, bus.res_valid, bus.res_src,
                               bus.frame_done, bus.err, bus.f_rst}), 32'h01);
    check("rst_f_din", 32'(bus.f_din), 32'd0);
    check("rst_res_out", 32'(bus.res_out), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_f_rst", 32'(bus.f_rst), 32'd0);

    for (int i = 0; i < 10; i++)
      run_frame(tbl[i].r0, tbl[i].r1, tbl[i].gap, tbl[i].stuck, 1'b0,
                tbl[i].exp_src, tbl[i].exp_err, $sformatf("tbl%0d", i));

    // reset in burst cycle 10
    stuck_mode = 0;
    new_pixels();
    bus.req0 = 1'b1;
    n = 0;
    while (!bus.gnt0 && n < 20) begin tick(); n++; end
    check("mid_rst_granted", 32'(bus.gnt0), 32'd1);
    bus.req0 = 1'b0;
    fvalid_cnt = 0;
    feed(0, 1'b0);
    n = 0;
    while (fvalid_cnt == 0 && n < 20) begin tick(); n++; end
    check("mid_rst_burst_seen", 32'(fvalid_cnt), 32'd1);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl_vec", 32'({bus.gnt0, bus.gnt1, bus.f_valid, bus.res_valid,
                                   bus.frame_done, bus.err, bus.f_rst}), 32'h01);
    check("mid_rst_f_din", 32'(bus.f_din), 32'd0);
    done_cnt = 0; err_cnt = 0; obs_res.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    last_served = 1;
    repeat (40) tick();
    check("mid_rst_pulses", 32'(done_cnt + err_cnt + obs_res.size()), 32'd0);
    $display("frame mid_rst aborted done=%0d err=%0d results=%0d", done_cnt, err_cnt, obs_res.size());
    run_frame(1, 1, 0, 0, 0, 0, 0, "post_rst");

    // back-to-back with req1 held
    res_base = res_total;
    run_frame(0, 1, 0, 0, 1'b1, 1, 0, "b2b_a");
    d = done_cyc;
    run_frame(0, 1, 0, 0, 1'b0, 1, 0, "b2b_b");
    check("b2b_regrant_delay", 32'(grant_cyc - d), 32'd2);
    check("b2b_total_results", 32'(res_total - res_base), 32'(2 * NRES));

    for (int i = 0; i < 8; i++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r1 = 1'b1;
      g = 1'($urandom);
      s = ($urandom_range(0, 4) == 0);
      exp = (r0 && r1) ? (last_served == 1 ? 0 : 1) : (r1 ? 1 : 0);
      run_frame(r0, r1, g, s, 1'b0, exp, s, $sformatf("rnd%0d", i));
    end

    check("invariants", 32'(inv_viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_arbiter.md
FRAME_ARBITER -- requirements
Module: frame_arbiter

Interface
REQ-001 Parameters SHALL be: N, default 5, image rows; M, default 5, image columns; WD_LIM, default 32, watchdog limit in cycles.
REQ-002 clk  input  1  single clock; all flops update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  frame request from source 0 or source 1; level signal.
REQ-005 vld0, vld1  input  1 each  pixel valid from source 0 or source 1.
REQ-006 din0, din1  input  8 each  pixel byte from source 0 or source 1.
REQ-007 gnt0, gnt1  output  1 each  grant to source 0 or source 1; one-hot or zero.
REQ-008 f_valid  output  1  start strobe to the shared filter engine.
REQ-009 f_din  output  8  pixel byte to the filter engine.
REQ-010 f_rst  output  1  active-high reset to the filter engine.
REQ-011 f_fill_now  input  1  filter status; low while the filter is convolving.
REQ-012 f_dout  input  16  filter result.
REQ-013 res_out  output  16  captured result.
REQ-014 res_valid  output  1  one-cycle qualifier for res_out.
REQ-015 res_src  output  1  source index of the current frame.
REQ-016 frame_done  output  1  one-cycle pulse when a frame completes normally.
REQ-017 err  output  1  one-cycle pulse on a watchdog timeout.

Function
REQ-018 The block SHALL implement the FSM states IDLE, COLLECT, BURST, WAIT, DRAIN and DONE.
REQ-019 The block SHALL hold an internal N*M-byte frame buffer, a pixel counter, a result counter, a watchdog counter and a 1-bit priority register.
REQ-020 In IDLE, the block SHALL grant the requesting source: a single request wins outright; with both requesting, the source not granted last wins (round-robin).
REQ-021 On granting, the block SHALL assert the grant in the next cycle and go to COLLECT.
REQ-022 req0 and req1 SHALL be sampled only in IDLE; once granted, a source keeps its grant until DONE or a timeout.
REQ-023 COLLECT: on each cycle with the granted vld high, the block SHALL write the granted din to buffer[pixel count] and increment the count.
REQ-024 COLLECT: vld and din of the non-granted source SHALL be ignored.
REQ-025 COLLECT: after the N*M-th write, the block SHALL reset the pixel count and go to BURST.
REQ-026 BURST SHALL last exactly N*M+1 cycles, with f_valid=1 in cycle 0 only.
REQ-027 In BURST cycles k=1..N*M, f_din SHALL equal buffer[k-1]; no gaps are allowed, because the filter stores one byte per cycle unconditionally.
REQ-028 After BURST, the block SHALL go to WAIT; f_valid SHALL be 0 and f_din SHALL be 0 in every state except BURST.
REQ-029 WAIT: when f_fill_now=0, the block SHALL go to DRAIN with the low-cycle count set to 1 (the first FIX cycle).
REQ-030 DRAIN: for each low cycle c=1,2,..., on every even c the block SHALL register f_dout into res_out and assert res_valid the following cycle.
REQ-031 DRAIN: after (N-2)*(M-2) results with f_fill_now=1, the block SHALL go to DONE.
REQ-032 DONE SHALL last one cycle: frame_done=1, grants dropped, priority set to the served source, next state IDLE.
REQ-033 A new grant SHALL be possible in the cycle after DONE.
REQ-034 res_src SHALL hold the served index from grant until the next grant.
REQ-035 res_out SHALL hold its value between captures.
REQ-036 Watchdog: in WAIT or DRAIN, if WD_LIM cycles pass without reaching DONE, the block SHALL pulse err and f_rst for 1 cycle, drop grants, discard results and go to IDLE.
REQ-037 On a watchdog timeout, priority SHALL still rotate.
REQ-038 A res_valid pulse SHALL NOT coincide with err.
REQ-039 Buffer contents SHALL be undefined after reset and overwritten in full for every frame.

Reset
REQ-040 While rst_n=0, the block SHALL be in IDLE with priority favouring source 0.
REQ-041 While rst_n=0, all outputs SHALL be 0 except f_rst=1 (combinational from rst_n).
REQ-042 A reset asserted mid-frame SHALL abort the frame immediately, with no frame_done, err or res_valid.
REQ-043 On the first edge after rst_n rises, the block SHALL evaluate requests normally.

Verification
REQ-044 Single frame: req0=1, 25 consecutive pixels 1..25, behavioural filter model -> gnt0 high; f_valid strobe; f_din=1..25 on the next 25 cycles; 9 res_valid pulses; frame_done after the 9th result; gnt0 low.
REQ-045 Contention: req0=req1=1 from reset -> source 0 served first, then source 1 with res_src=1; next simultaneous request -> source 0.
REQ-046 Gapped input: granted vld toggling 1,0,1,0 with 25 pixels -> BURST still contiguous and identical to the captured bytes; vld of the non-granted source has no effect.
REQ-047 Stuck filter: f_fill_now held at 1 after BURST -> err and f_rst pulse exactly WD_LIM cycles after entering WAIT; grant dropped; IDLE.
REQ-048 Reset mid-BURST (cycle 10): rst_n low -> f_valid=0, grants 0, f_rst=1 at once; no frame_done; clean frame after release.
REQ-049 Back-to-back: req1 held continuously for two frames -> second grant in the cycle after DONE; two frame_done pulses; 18 results total.
